// File: rtl/apb_master_port.sv
// APB initiator: one valid/ready command becomes one SETUP/ACCESS transfer, answered on a held response channel.
// Optional ACCESS watchdog is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_port #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                  state_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_error_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q;

  // Abort on the edge that closes the TIMEOUT_CYCLES-th wait cycle; PREADY=1 in that cycle still completes.
  assign timeout_hit = (state_q == S_ACCESS) && !PREADY && (wait_cnt_q == TimeoutLast);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !PREADY && wait_cnt_q != 8'hFF) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            psel_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_error_q <= 1'b0;
            state_q     <= S_RESP;
          end else if (timeout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_port.sv
// Self-checking bench for apb_master_port: directed scenarios plus randomized transfers against a latency/response model.
module tb_apb_master_port;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int T  = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            waits;
    logic [DW-1:0] rd;
    int            hold;
  } txn_t;

  apb_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_psel_pen"},  {PSEL, PENABLE}, 0);
    check({tag, "_pwrite"},    PWRITE, 0);
    check({tag, "_paddr"},     PADDR, 0);
    check({tag, "_pwdata"},    PWDATA, 0);
  endtask

  // One complete transfer. The expected latency and response come from the protocol rules:
  // 3 cycles plus one per wait state, or an abort after T wait cycles when the watchdog exists.
  task automatic run_txn(input txn_t t, input bit have_next, input txn_t nx);
    int   budget, lat, acc;
    bit   abort, stable_ok, hold_ok;
    int   exp_lat;
    logic [DW-1:0] exp_rd;

    abort   = TO_EN && (t.waits >= T);
    exp_lat = abort ? 2 + T : 3 + t.waits;
    exp_rd  = (abort || t.w) ? '0 : t.rd;

    cmd_valid = 1'b1; cmd_write = t.w; cmd_addr = t.a; cmd_wdata = t.d; rsp_ready = 1'b0;
    budget = 0;
    while (!cmd_ready && budget < 20) begin
      tick();
      budget++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;

    check("setup_psel_pen", {PSEL, PENABLE}, 2'b10);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_rsp_valid", rsp_valid, 0);
    check("setup_paddr", PADDR, t.a);
    check("setup_pwrite", PWRITE, t.w);
    check("setup_pwdata", PWDATA, t.d);

    lat = 1; acc = 0; stable_ok = 1'b1;
    while (!rsp_valid && lat < 400) begin
      if (PSEL && PENABLE) begin
        PREADY = (acc == t.waits);
        PRDATA = (acc == t.waits) ? t.rd : $urandom;
        acc++;
      end else begin
        PREADY = 1'($urandom);
        PRDATA = $urandom;
      end
      if (PSEL && (PADDR !== t.a || PWRITE !== t.w || PWDATA !== t.d)) stable_ok = 1'b0;
      tick();
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    check("bus_stable", stable_ok, 1);
    check("rsp_valid", rsp_valid, 1);
    check("resp_psel_pen", {PSEL, PENABLE}, 0);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_error", rsp_error, abort);

    if (have_next) begin
      cmd_valid = 1'b1; cmd_write = nx.w; cmd_addr = nx.a; cmd_wdata = nx.d;
    end
    hold_ok = 1'b1;
    for (int h = 0; h < t.hold; h++) begin
      PREADY = 1'($urandom);
      PRDATA = $urandom;
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_error !== abort ||
          cmd_ready !== 1'b0 || PSEL !== 1'b0) hold_ok = 1'b0;
    end
    check("rsp_hold", hold_ok, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  txn_t q[$];
  txn_t dummy;

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0;
    dummy = '{w: 1'b0, a: '0, d: '0, waits: 0, rd: '0, hold: 0};

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
      cmd_wdata = $urandom; rsp_ready = 1'($urandom); PREADY = 1'($urandom); PRDATA = $urandom;
      tick();
    end
    check_reset_outputs("rst");
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    #3 PRESETn = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // Directed: zero-wait write, 3-wait read, 5-cycle back-pressure with a second command held.
    q.push_back('{w: 1'b1, a: 5'h0C, d: 32'h0000_00A5, waits: 0, rd: 32'hDEAD_BEEF, hold: 0});
    q.push_back('{w: 1'b0, a: 5'h08, d: 32'h1234_5678, waits: 3, rd: 32'h0000_00C4, hold: 5});
    q.push_back('{w: 1'b0, a: 5'h1F, d: 32'hFFFF_FFFF, waits: 0, rd: 32'hFFFF_FFFF, hold: 1});
    if (TO_EN) q.push_back('{w: 1'b0, a: 5'h04, d: 32'h0, waits: 50, rd: 32'h5A5A_5A5A, hold: 2});
    for (int i = 0; i < 30; i++) begin
      q.push_back('{w: 1'($urandom), a: AW'($urandom), d: $urandom,
                    waits: $urandom_range(0, 6), rd: $urandom, hold: $urandom_range(0, 4)});
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i + 1 < q.size()) run_txn(q[i], 1'b1, q[i+1]);
      else                  run_txn(q[i], 1'b0, dummy);
    end
    cmd_valid = 1'b0;
    tick();

    // Without the watchdog ACCESS waits forever; with it, a stalled slave is abandoned.
    if (!TO_EN) begin
      bit stall_ok;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h10; cmd_wdata = '0;
      tick();
      cmd_valid = 1'b0;
      PREADY = 1'b0;
      stall_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (PSEL !== 1'b1 || rsp_valid !== 1'b0) stall_ok = 1'b0;
      end
      check("no_timeout_stall", stall_ok, 1);
      #2 PRESETn = 1'b0;
      #1 PRESETn = 1'b1;
      tick();
    end

    // Reset in the middle of ACCESS drops the bus without a clock edge.
    begin
      int budget;
      bit quiet_ok;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h03; cmd_wdata = 32'hCAFE_0001;
      PREADY = 1'b0;
      budget = 0;
      while (!(PSEL && PENABLE) && budget < 10) begin
        tick();
        cmd_valid = 1'b0;
        budget++;
      end
      check("midrst_in_access", {PSEL, PENABLE}, 2'b11);
      #2 PRESETn = 1'b0;
      #1;
      check("midrst_psel_pen", {PSEL, PENABLE}, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      tick();
      #2 PRESETn = 1'b1;
      PREADY = 1'b1; PRDATA = $urandom; rsp_ready = 1'b0; cmd_valid = 1'b0;
      quiet_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (rsp_valid !== 1'b0 || PSEL !== 1'b0) quiet_ok = 1'b0;
      end
      check("midrst_no_rsp", quiet_ok, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
